// File: rtl/msu_seq_pkg.sv
// Shared types and widths for the modular-squaring-unit job sequencer.
// spread_lanes maps a packed seed onto the MSU's 32-bit coefficient lanes.
package msu_seq_pkg;

    localparam int MOD_LEN      = 1024;
    localparam int WORD_LEN     = 16;
    localparam int NUM_ELEMENTS = MOD_LEN / WORD_LEN + 1;
    localparam int LANE_LEN     = 2 * WORD_LEN;
    localparam int SQ_OUT_BITS  = NUM_ELEMENTS * LANE_LEN;
    localparam int T_LEN        = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_ABORTED = 2'd1,
        STAT_TIMEOUT = 2'd2
    } status_t;

    // Each WORD_LEN word goes zero-extended into its own lane; the redundant top lane stays 0.
    function automatic logic [SQ_OUT_BITS-1:0] spread_lanes(input logic [MOD_LEN-1:0] x);
        logic [SQ_OUT_BITS-1:0] lanes;
        lanes = '0;
        for (int i = 0; i < MOD_LEN / WORD_LEN; i++) begin
            lanes[i*LANE_LEN +: WORD_LEN] = x[i*WORD_LEN +: WORD_LEN];
        end
        return lanes;
    endfunction

endpackage

// File: rtl/msu_seq_if.sv
// Job, MSU-control and result signals of the sequencer, bundled with directional modports.
// Handshakes (job_*, res_*): a transfer happens on a cycle where valid and ready are both high; a raised valid and its payload stay stable until that cycle.
interface msu_seq_if;
    import msu_seq_pkg::*;

    logic                   job_valid;
    logic                   job_ready;
    logic [MOD_LEN-1:0]     job_x;
    logic [T_LEN-1:0]       job_t;
    logic                   abort;
    logic                   msu_reset;
    logic                   msu_start;
    logic [MOD_LEN-1:0]     msu_sq_in;
    logic [SQ_OUT_BITS-1:0] msu_sq_out;
    logic                   msu_valid;
    logic                   res_valid;
    logic                   res_ready;
    logic [SQ_OUT_BITS-1:0] res_data;
    logic [T_LEN-1:0]       res_iters;
    logic [1:0]             res_status;
    logic                   busy;
    state_t                 dbg_state;

    modport master (
        input  job_valid, job_x, job_t, abort, msu_sq_out, msu_valid, res_ready,
        output job_ready, msu_reset, msu_start, msu_sq_in, res_valid, res_data,
               res_iters, res_status, busy, dbg_state
    );

    modport slave (
        output job_valid, job_x, job_t, abort, msu_sq_out, msu_valid, res_ready,
        input  job_ready, msu_reset, msu_start, msu_sq_in, res_valid, res_data,
               res_iters, res_status, busy, dbg_state
    );

endinterface

// File: rtl/msu_seq_timer.sv
// Loadable down-counter; done_o marks the last cycle of a MAX_CYCLES-long count.
module msu_seq_timer #(
    parameter int unsigned MAX_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int W = $clog2(MAX_CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(MAX_CYCLES);
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/msu_sequencer.sv
// Runs one VDF job on the modular-squaring unit: clears and starts it, counts squarings,
// captures the T-th output and returns it with a completion status.
module msu_sequencer
    import msu_seq_pkg::*;
#(
    parameter int unsigned CLR_CYCLES  = 4,
    parameter int unsigned WDOG_CYCLES = 256
) (
    input logic       clk,
    input logic       reset,
    msu_seq_if.master bus
);

    state_t                 state_q, state_d;
    status_t                status_q, status_d;
    logic [MOD_LEN-1:0]     x_q, x_d;
    logic [T_LEN-1:0]       t_q, t_d, iter_q, iter_d, iters_q, iters_d, iter_inc;
    logic [SQ_OUT_BITS-1:0] data_q, data_d;
    logic accept, in_run, final_sq, abort_go, timeout;
    logic hold_load, hold_en, hold_done, wdog_load, wdog_en, wdog_done;

    assign accept   = (state_q == ST_IDLE) && bus.job_valid;
    assign in_run   = (state_q == ST_RUN);
    assign iter_inc = iter_q + T_LEN'(1);
    assign final_sq = in_run && bus.msu_valid && (iter_inc == t_q);
    // A cancel arriving with the final squaring loses to the completion.
    assign abort_go = bus.abort && !final_sq &&
                      (state_q == ST_CLEAR || state_q == ST_START || in_run);
    assign timeout  = in_run && !bus.msu_valid && wdog_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (bus.job_t == '0) ? ST_DONE : ST_CLEAR;
            ST_CLEAR: begin
                if (abort_go)       state_d = ST_DRAIN;
                else if (hold_done) state_d = ST_START;
            end
            ST_START: state_d = abort_go ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (final_sq || abort_go || timeout) state_d = ST_DRAIN;
            ST_DRAIN: if (hold_done) state_d = ST_DONE;
            ST_DONE:  if (bus.res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_d      = x_q;
        t_d      = t_q;
        iter_d   = iter_q;
        data_d   = data_q;
        iters_d  = iters_q;
        status_d = status_q;
        if (accept) begin
            x_d    = bus.job_x;
            t_d    = bus.job_t;
            iter_d = '0;
            if (bus.job_t == '0) begin
                data_d   = spread_lanes(bus.job_x);
                iters_d  = '0;
                status_d = STAT_OK;
            end
        end
        if (state_q == ST_START) iter_d = '0;
        if (in_run && bus.msu_valid) iter_d = iter_inc;
        if (final_sq) begin
            data_d   = bus.msu_sq_out;
            iters_d  = t_q;
            status_d = STAT_OK;
        end else if (abort_go) begin
            iters_d  = iter_d;
            status_d = STAT_ABORTED;
        end else if (timeout) begin
            iters_d  = iter_q;
            status_d = STAT_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            t_q      <= '0;
            iter_q   <= '0;
            data_q   <= '0;
            iters_q  <= '0;
            status_q <= STAT_OK;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            t_q      <= t_d;
            iter_q   <= iter_d;
            data_q   <= data_d;
            iters_q  <= iters_d;
            status_q <= status_d;
        end
    end

    // One timer paces both MSU-reset windows; it reloads on every entry to CLEAR or DRAIN.
    assign hold_load = (state_d != state_q) && (state_d == ST_CLEAR || state_d == ST_DRAIN);
    assign hold_en   = (state_q == ST_CLEAR) || (state_q == ST_DRAIN);
    assign wdog_load = (state_q == ST_START) || (in_run && bus.msu_valid);
    assign wdog_en   = in_run;

    msu_seq_timer #(.MAX_CYCLES(CLR_CYCLES)) u_hold_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (hold_load),
        .en_i   (hold_en),
        .done_o (hold_done)
    );

    msu_seq_timer #(.MAX_CYCLES(WDOG_CYCLES)) u_wdog_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (wdog_load),
        .en_i   (wdog_en),
        .done_o (wdog_done)
    );

    assign bus.job_ready  = (state_q == ST_IDLE);
    assign bus.msu_reset  = !((state_q == ST_START) || in_run);
    assign bus.msu_start  = (state_q == ST_START);
    assign bus.msu_sq_in  = x_q;
    assign bus.res_valid  = (state_q == ST_DONE);
    assign bus.res_data   = data_q;
    assign bus.res_iters  = iters_q;
    assign bus.res_status = status_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/msu_sequencer.md
Name: msu_sequencer

Overview:
Controls the pipelined modular-squaring unit (MSU) for one VDF evaluation job. It accepts a job containing a seed x and an iteration count T, then clears and starts the MSU. The MSU free-runs and asserts sq_valid once per squaring; the sequencer counts these pulses and captures the coefficient-form output on the T-th pulse. It then stops the MSU and returns the result with a completion status through a valid/ready handshake.

Parameters:
MOD_LEN, 1024, modulus width in bits; width of the seed.
WORD_LEN, 16, bits per non-redundant coefficient.
NUM_ELEMENTS, MOD_LEN/WORD_LEN+1, coefficient count including one redundant element.
SQ_OUT_BITS, NUM_ELEMENTS*WORD_LEN*2, width of the MSU output bus (each coefficient in a 32-bit lane).
T_LEN, 64, width of the iteration count.
CLR_CYCLES, 4, number of cycles msu_reset is held in CLEAR and DRAIN (minimum 1).
WDOG_CYCLES, 256, maximum idle cycles between MSU valid pulses in RUN before timeout (minimum 1).

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
job_valid  in  1  job offer
job_ready  out  1  sequencer can accept a job
job_x  in  MOD_LEN  seed value
job_t  in  T_LEN  number of squarings
abort  in  1  single-cycle request to cancel the running job
msu_reset  out  1  reset to the MSU
msu_start  out  1  one-cycle start pulse to the MSU
msu_sq_in  out  MOD_LEN  seed held stable from job accept until the next job accept
msu_sq_out  in  SQ_OUT_BITS  MSU coefficient output
msu_valid  in  1  MSU iteration-complete pulse
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
res_data  out  SQ_OUT_BITS  captured coefficients
res_iters  out  T_LEN  iterations completed
res_status  out  2  0=OK, 1=ABORTED, 2=TIMEOUT
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state=IDLE; job_ready=1; msu_reset=1; msu_start=0; res_valid=0; res_status=0; res_iters=0; res_data=0; msu_sq_in=0; busy=0. All counters are 0.
- States: IDLE, CLEAR, START, RUN, DRAIN, DONE.
- IDLE: job_ready=1 and msu_reset=1. A job is accepted when job_valid and job_ready are both high: job_x is latched into msu_sq_in and job_t is latched internally.
  - If job_t==0: go directly to DONE. res_data = job_x with each WORD_LEN word zero-extended into its 32-bit lane; the redundant lane is 0; res_iters=0; status OK.
  - Otherwise: go to CLEAR.
- CLEAR: hold msu_reset=1 for CLR_CYCLES cycles, then go to START.
- START: msu_reset=0, msu_start=1 for exactly one cycle, then go to RUN. The iteration counter and the watchdog counter are zeroed on entry.
- RUN: msu_reset=0.
  - Each msu_valid cycle increments iter_cnt and zeroes the watchdog.
  - On the msu_valid cycle where iter_cnt+1==T: capture msu_sq_out into res_data, set res_iters=T and status OK, then go to DRAIN.
  - Watchdog: counts cycles without msu_valid. When it reaches WDOG_CYCLES: status TIMEOUT, res_iters=iter_cnt, res_data unchanged, go to DRAIN.
- abort: while in CLEAR, START or RUN → status ABORTED, res_iters=iter_cnt, res_data unchanged, go to DRAIN.
  - If abort coincides with the final msu_valid, the completion wins: status OK.
  - abort in IDLE, DRAIN or DONE is ignored.
- DRAIN: msu_reset=1 for CLR_CYCLES cycles, then go to DONE. msu_valid is ignored.
- DONE: res_valid=1 and res_data/res_iters/res_status are held stable until res_ready. On the res_valid & res_ready cycle go to IDLE; res_valid falls the next cycle.
  - job_ready=0 in every state except IDLE, so at most one job is outstanding.
- msu_valid outside RUN is ignored and not counted.
- Latency: from job accept to the first possible msu_valid sampling is CLR_CYCLES+2 cycles. From the final msu_valid to res_valid is CLR_CYCLES+1 cycles.
- iter_cnt is T_LEN bits wide and cannot wrap before T is reached.
- Asserting reset mid-job returns all outputs to their reset values immediately; any pending result is lost.

Decomposition:
- Package msu_seq_pkg: state enum (state_t), status encoding (STAT_OK, STAT_ABORTED, STAT_TIMEOUT), and a function that spreads a MOD_LEN value into SQ_OUT_BITS lanes.
- One natural sub-module, msu_seq_timer: a loadable down-counter with a done flag, instantiated twice — once for the CLEAR/DRAIN hold and once for the watchdog.

Test Plan:
All scenarios use a behavioural MSU model (x^2 mod N, with msu_valid every 8 cycles after msu_start).
- N=1019 (padded), x=3, T=1 → res_data lane0=9, res_iters=1, STAT_OK; res_valid first rises CLR_CYCLES+1 cycles after the msu_valid pulse.
- x=3, T=3 → res_data lane0 = 3^8 mod 1019 = 447, res_iters=3; exactly 3 valids counted; msu_reset=1 at DONE.
- T=0, x=0x1234 → DONE within 1 cycle of accept; lane0=0x00001234; msu_start never pulses.
- T=100, abort after the 5th msu_valid → STAT_ABORTED, res_iters=5. Variant: abort on the same cycle as the T-th valid → STAT_OK.
- Model stalls after 2 valids, WDOG_CYCLES=16 → STAT_TIMEOUT, res_iters=2, exactly 16 idle cycles elapse before DRAIN.
- Hold res_ready=0 for 20 cycles in DONE, offer job_valid throughout → outputs stable and job_ready=0 for all 20 cycles; asserting reset mid-RUN → job_ready=1, res_valid=0, msu_reset=1 immediately (asynchronous).
